line_pair_feeder: RTL

LINE_PAIR_FEEDER -- requirements
Module: line_pair_feeder

---
 rtl/line_pair_feeder_pkg.sv | 16 +
 rtl/line_pair_feeder_if.sv | 33 +++
 rtl/line_pair_feeder_skid.sv | 46 ++++
 rtl/line_pair_feeder.sv | 134 +++++++++++++
 4 files changed

// File: rtl/line_pair_feeder_pkg.sv
// Shared coefficient width, {odd, even} pair type and the feeder's state encodings.
package line_pair_feeder_pkg;

  localparam int DataWidth = 16;

  typedef struct packed {
    logic [DataWidth-1:0] odd;
    logic [DataWidth-1:0] even;
  } pair_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  // Pre-extension pairs, natural pairs, post-extension pairs.
  typedef enum logic [1:0] {PH_PRE, PH_MAIN, PH_POST} phase_t;

endpackage

// File: rtl/line_pair_feeder_if.sv
// Dual-port line memory read side plus the line-pair output stream of the feeder.
interface line_pair_feeder_if #(
  parameter int DataWidth = 16,
  parameter int SideSize  = 16
);
  localparam int AddrWidth = $clog2(SideSize);

  logic                   mem_rd_o;
  logic [AddrWidth-1:0]   mem_even_row_o;
  logic [AddrWidth-1:0]   mem_odd_row_o;
  logic [AddrWidth-1:0]   mem_col_o;
  logic [DataWidth-1:0]   mem_even_i;
  logic [DataWidth-1:0]   mem_odd_i;
  logic                   m_valid_o;
  logic                   m_ready_i;
  logic                   m_sof_o;
  logic                   m_eol_o;
  logic [2*DataWidth-1:0] m_data_o;

  modport master (
    output mem_rd_o, mem_even_row_o, mem_odd_row_o, mem_col_o,
    input  mem_even_i, mem_odd_i,
    output m_valid_o, m_sof_o, m_eol_o, m_data_o,
    input  m_ready_i
  );

  modport slave (
    input  mem_rd_o, mem_even_row_o, mem_odd_row_o, mem_col_o,
    output mem_even_i, mem_odd_i,
    input  m_valid_o, m_sof_o, m_eol_o, m_data_o,
    output m_ready_i
  );
endinterface

// File: rtl/line_pair_feeder_skid.sv
// Two-entry output buffer with empty bypass: zero latency when empty, holds up to two stalled beats.
// No input ready; the producer issues only while room is high (room counts the datum arriving now).
module skid_buffer #(
  parameter int Width = 34
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             s_vld,
  input  logic [Width-1:0] s_dat,
  output logic             m_vld,
  input  logic             m_rdy,
  output logic [Width-1:0] m_dat,
  output logic [1:0]       level,
  output logic             room
);
  logic [Width-1:0] mem_q [2];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       cnt_q;
  logic             push;
  logic             pop;

  // A fresh datum is stored only if it cannot leave straight through the bypass.
  assign push  = s_vld && !((cnt_q == 2'd0) && m_rdy);
  assign pop   = (cnt_q != 2'd0) && m_rdy;
  assign m_vld = (cnt_q != 2'd0) || s_vld;
  assign m_dat = (cnt_q != 2'd0) ? mem_q[rd_ptr_q] : s_dat;
  assign level = cnt_q;
  assign room  = (cnt_q == 2'd0) || ((cnt_q == 2'd1) && !s_vld);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= s_dat;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/line_pair_feeder.sv
// Streams a tile as symmetric-extended (even, odd) row pairs, column by column; first read 1 cycle
// and first beat 2 cycles after start. Stalls hold the beat stable; reads pause while the skid is full.
module line_pair_feeder
  import line_pair_feeder_pkg::*;
#(
  parameter int DataWidth = line_pair_feeder_pkg::DataWidth,
  parameter int SideSize  = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  line_pair_feeder_if.master bus
);
  localparam int AddrWidth    = $clog2(SideSize);
  localparam int PayloadWidth = 2*DataWidth + 2;
  localparam logic [AddrWidth-1:0] LastCol  = AddrWidth'(SideSize - 1);
  localparam logic [AddrWidth-1:0] LastEven = AddrWidth'(SideSize - 2);
  localparam logic [AddrWidth-1:0] One      = AddrWidth'(1);
  localparam logic [AddrWidth-1:0] Two      = AddrWidth'(2);
  localparam logic [AddrWidth-1:0] Four     = AddrWidth'(4);

  state_t                  state_q, state_d;
  phase_t                  phase_q;
  logic                    second_q;
  logic [AddrWidth-1:0]    even_q;
  logic [AddrWidth-1:0]    col_q;
  logic                    rd, rd_q, sof_q, eol_q, done_q;
  logic                    room, last_rd, final_beat;
  logic [1:0]              level;
  logic                    out_vld;
  logic [PayloadWidth-1:0] out_dat;

  assign last_rd    = (phase_q == PH_POST) && second_q && (col_q == LastCol);
  // Exactly one beat left: either the last read is still in flight or it sits alone in the skid.
  assign final_beat = ((level == 2'd0) && rd_q) || ((level == 2'd1) && !rd_q);

  always_comb begin
    state_d = state_q;
    rd      = 1'b0;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_RUN;
      ST_RUN: begin
        rd = room;
        if (room && last_rd) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (out_vld && bus.m_ready_i && final_beat) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_DRAIN) && (state_d == ST_IDLE);
      rd_q    <= rd;
      sof_q   <= rd && (phase_q == PH_PRE) && !second_q && (col_q == '0);
      eol_q   <= rd && (col_q == LastCol);
    end
  end

  // Even row walks 4,2 / 0..N-2 / N-2,N-4; the odd row is its neighbour, above or below by phase.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q  <= PH_MAIN;
      second_q <= 1'b0;
      even_q   <= '0;
      col_q    <= '0;
    end else if ((state_q == ST_IDLE) && start_i) begin
      phase_q  <= PH_PRE;
      second_q <= 1'b0;
      even_q   <= Four;
      col_q    <= '0;
    end else if (rd) begin
      if (col_q == LastCol) begin
        col_q <= '0;
        case (phase_q)
          PH_PRE: begin
            if (second_q) begin
              phase_q  <= PH_MAIN;
              second_q <= 1'b0;
              even_q   <= '0;
            end else begin
              second_q <= 1'b1;
              even_q   <= even_q - Two;
            end
          end
          PH_MAIN: begin
            if (even_q == LastEven) phase_q <= PH_POST;
            else                    even_q  <= even_q + Two;
          end
          default: begin
            if (!second_q) begin
              second_q <= 1'b1;
              even_q   <= even_q - Two;
            end
          end
        endcase
      end else begin
        col_q <= col_q + One;
      end
    end
  end

  skid_buffer #(.Width(PayloadWidth)) u_skid (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .s_vld (rd_q),
    .s_dat ({eol_q, sof_q, bus.mem_odd_i, bus.mem_even_i}),
    .m_vld (out_vld),
    .m_rdy (bus.m_ready_i),
    .m_dat (out_dat),
    .level (level),
    .room  (room)
  );

  assign bus.mem_rd_o       = rd;
  assign bus.mem_even_row_o = even_q;
  assign bus.mem_odd_row_o  = (phase_q == PH_MAIN) ? even_q + One : even_q - One;
  assign bus.mem_col_o      = col_q;
  assign bus.m_valid_o      = out_vld;
  assign bus.m_data_o       = out_dat[2*DataWidth-1:0];
  assign bus.m_sof_o        = out_vld && out_dat[2*DataWidth];
  assign bus.m_eol_o        = out_vld && out_dat[2*DataWidth+1];
  assign busy_o             = (state_q != ST_IDLE);
  assign done_o             = done_q;
endmodule
